// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 host-to-device transmit path.
//   ps2_state_e  : transmitter FSM states
//   ST_*         : completion status codes reported with o_done
//   FRAME_FALLS  : device falling edges in one host frame (8 data, parity,
//                  stop, ack)
//   odd_parity() : parity bit that makes the 9-bit {parity, data} word odd
// ---------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      SHIFT,
      WAIT_IDLE,
      DONE
   } ps2_state_e;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_NOACK   = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;

   localparam logic [3:0] FRAME_FALLS = 4'd11;

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
// Conditions one asynchronous PS/2 pad level: 2-flop synchronizer, a
// FILT_LEN-sample glitch filter and a registered falling-edge flag.
// Pad edge to o_fall latency is 2 + FILT_LEN + 1 i_clk cycles.
// Ports:
//   i_clk, i_rst : system clock, synchronous active-high reset
//   i_pad        : raw pad level (asynchronous)
//   o_level      : filtered level (resets high, the idle bus level)
//   o_fall       : one-cycle pulse after the filtered level goes 1->0
// ---------------------------------------------------------------------------
module ps2_line_filter #(
   parameter int FILT_LEN = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_pad,
   output logic o_level,
   output logic o_fall
);

   localparam int CW = $clog2(FILT_LEN + 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          level_prev_q;
   logic          fall_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         level_q      <= 1'b1;
         level_prev_q <= 1'b1;
         fall_q       <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sync1_q      <= i_pad;
         sync2_q      <= sync1_q;
         level_prev_q <= level_q;
         fall_q       <= level_prev_q & ~level_q;
         // Count consecutive samples that disagree with the accepted level;
         // any agreeing sample restarts the count, so short glitches die here.
         if (sync2_q != level_q) begin
            if (cnt_q == CW'(FILT_LEN - 1)) begin
               level_q <= sync2_q;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign o_level = level_q;
   assign o_fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Inhibits the bus, issues request-to-send,
// shifts data/odd parity/stop on device clocks, samples the device ack and
// reports a status with a one-cycle o_done pulse.
// Ports:
//   i_clk, i_rst               : system clock, synchronous active-high reset
//   i_tx_valid, i_tx_data      : command byte offer
//   o_tx_ready                 : high only in IDLE
//   o_busy                     : high from acceptance through DONE
//   o_done, o_status           : completion pulse and status (00 ok,
//                                01 no ack, 10 timeout)
//   i_ps2_clk, i_ps2_dat       : raw pad levels
//   o_ps2_clk_oe, o_ps2_dat_oe : 1 = pull the open-drain line low
// Handshake: a byte is taken on the rising edge where i_tx_valid and
// o_tx_ready are both high; i_tx_valid at any other time is ignored and
// nothing is queued.
// ---------------------------------------------------------------------------
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYC = 6000,
   parameter int TIMEOUT_CYC = 750000,
   parameter int FILT_LEN    = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_tx_valid,
   input  logic [7:0] i_tx_data,
   output logic       o_tx_ready,
   output logic       o_busy,
   output logic       o_done,
   output logic [1:0] o_status,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_dat,
   output logic       o_ps2_clk_oe,
   output logic       o_ps2_dat_oe
);

   localparam int IW = $clog2(INHIBIT_CYC);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   ps2_state_e    state_q;
   logic [IW-1:0] inh_cnt_q;
   logic [TW-1:0] tmo_cnt_q;
   logic [TW-1:0] tmo_cnt_d;
   logic [3:0]    fall_cnt_q;
   logic [3:0]    fall_cnt_d;
   logic [8:0]    shift_q;
   logic          clk_oe_q;
   logic          dat_oe_q;
   logic          done_q;
   logic          busy_q;
   logic          ready_q;
   logic [1:0]    status_q;
   logic          dat_s1_q;
   logic          dat_s2_q;
   logic          clk_level;
   logic          clk_fall;
   logic          tmo_hit;

   ps2_line_filter #(
      .FILT_LEN (FILT_LEN)
   ) u_clk_filter (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_pad   (i_ps2_clk),
      .o_level (clk_level),
      .o_fall  (clk_fall)
   );

   // Data only needs synchronizing: it is sampled at clock-edge flags and
   // checked for idle, never edge-detected.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         dat_s1_q <= i_ps2_dat;
         dat_s2_q <= dat_s1_q;
      end
   end

   // Saturating timeout count; it hits on the cycle that would make it
   // TIMEOUT_CYC, so the released lines appear TIMEOUT_CYC cycles after the
   // count was last cleared.
   always_comb begin
      tmo_cnt_d  = (tmo_cnt_q == TW'(TIMEOUT_CYC)) ? tmo_cnt_q : tmo_cnt_q + TW'(1);
      tmo_hit    = (tmo_cnt_d == TW'(TIMEOUT_CYC));
      fall_cnt_d = fall_cnt_q + 4'd1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         inh_cnt_q  <= '0;
         tmo_cnt_q  <= '0;
         fall_cnt_q <= '0;
         shift_q    <= '0;
         clk_oe_q   <= 1'b0;
         dat_oe_q   <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
         status_q   <= ST_OK;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_tx_valid) begin
                  shift_q   <= {odd_parity(i_tx_data), i_tx_data};
                  busy_q    <= 1'b1;
                  ready_q   <= 1'b0;
                  clk_oe_q  <= 1'b1;
                  inh_cnt_q <= '0;
                  state_q   <= INHIBIT;
               end
            end
            INHIBIT: begin
               // clk_oe is visible for the INHIBIT_CYC-1 cycles here plus the
               // RTS cycle; dat goes low in RTS, one cycle before clk release.
               if (inh_cnt_q == IW'(INHIBIT_CYC - 2)) begin
                  dat_oe_q <= 1'b1;
                  state_q  <= RTS;
               end else begin
                  inh_cnt_q <= inh_cnt_q + IW'(1);
               end
            end
            RTS: begin
               clk_oe_q   <= 1'b0;
               fall_cnt_q <= '0;
               tmo_cnt_q  <= '0;
               state_q    <= SHIFT;
            end
            SHIFT: begin
               if (clk_fall) begin
                  tmo_cnt_q  <= '0;
                  fall_cnt_q <= fall_cnt_d;
                  if (fall_cnt_d <= 4'd9) begin
                     // Edges 1..9 put data LSB first, then parity, on the line.
                     dat_oe_q <= ~shift_q[0];
                     shift_q  <= {1'b0, shift_q[8:1]};
                  end else if (fall_cnt_d != FRAME_FALLS) begin
                     dat_oe_q <= 1'b0;
                  end else begin
                     status_q <= dat_s2_q ? ST_NOACK : ST_OK;
                     state_q  <= WAIT_IDLE;
                  end
               end else if (tmo_hit) begin
                  clk_oe_q <= 1'b0;
                  dat_oe_q <= 1'b0;
                  status_q <= ST_TIMEOUT;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_d;
               end
            end
            WAIT_IDLE: begin
               if (clk_level && dat_s2_q) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else if (clk_fall) begin
                  tmo_cnt_q <= '0;
               end else if (tmo_hit) begin
                  clk_oe_q <= 1'b0;
                  dat_oe_q <= 1'b0;
                  status_q <= ST_TIMEOUT;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_d;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               clk_oe_q <= 1'b0;
               dat_oe_q <= 1'b0;
               busy_q   <= 1'b0;
               ready_q  <= 1'b1;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign o_tx_ready   = ready_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_status     = status_q;
   assign o_ps2_clk_oe = clk_oe_q;
   assign o_ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Directed bench for ps2_host_tx with a behavioural PS/2 device. The open-
// drain bus is modelled as line = ~oe & device_drive. Expected device frames
// and completion statuses are queued when commands are issued and compared
// when the device receives a frame or the DUT signals o_done.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

   localparam int INHIBIT_CYC = 6000;
   localparam int TIMEOUT_CYC = 2000;
   localparam int FILT_LEN    = 4;
   localparam int HALF        = 40;

   logic       clk;
   logic       rst;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic [1:0] status;
   logic       clk_oe;
   logic       dat_oe;
   logic       dev_clk;
   logic       dev_dat;
   logic       ps2_clk_line;
   logic       ps2_dat_line;

   int n_assert;
   int n_fail;
   int done_cnt;
   int oe_run;
   int last_oe_run;

   logic [10:0] exp_q[$];
   logic [1:0]  exp_st_q[$];

   assign ps2_clk_line = ~clk_oe & dev_clk;
   assign ps2_dat_line = ~dat_oe & dev_dat;

   ps2_host_tx #(
      .INHIBIT_CYC (INHIBIT_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .FILT_LEN    (FILT_LEN)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_tx_valid   (tx_valid),
      .i_tx_data    (tx_data),
      .o_tx_ready   (tx_ready),
      .o_busy       (busy),
      .o_done       (done),
      .o_status     (status),
      .i_ps2_clk    (ps2_clk_line),
      .i_ps2_dat    (ps2_dat_line),
      .o_ps2_clk_oe (clk_oe),
      .o_ps2_dat_oe (dat_oe)
   );

   // ---------------- clock / watchdog ----------------
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   initial begin
      #(95000 * 20);
      $display("FAIL watchdog: observed no end of test, expected completion within 95000 cycles");
      $fatal(1, "watchdog expired");
   end

   // ---------------- monitors ----------------
   initial begin
      done_cnt    = 0;
      oe_run      = 0;
      last_oe_run = 0;
   end

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (clk_oe === 1'b1) begin
         oe_run++;
      end else begin
         if (oe_run > 0) last_oe_run = oe_run;
         oe_run = 0;
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] frame_of(input logic [7:0] d);
      logic par;
      par = (($countones(d) % 2) == 0);
      return {1'b1, par, d, 1'b0};
   endfunction

   task automatic send_cmd(input logic [7:0] d, input bit with_frame,
                           input bit with_status, input logic [1:0] st);
      int w;
      w = 0;
      @(negedge clk);
      while (tx_ready !== 1'b1 && w < 20000) begin
         @(negedge clk);
         w++;
      end
      check("ready_before_send", {31'd0, tx_ready}, 32'd1);
      tx_valid = 1'b1;
      tx_data  = d;
      if (with_frame) exp_q.push_back(frame_of(d));
      if (with_status) exp_st_q.push_back(st);
      @(negedge clk);
      tx_valid = 1'b0;
      check("busy_after_accept", {30'd0, tx_ready, busy}, 32'd1);
   endtask

   // Device side: waits for the host inhibit and release, then clocks 11
   // edges, sampling the data line on each rising edge.
   task automatic dev_rx(input bit ack, input int glitch_after, input int abort_after,
                         output logic [10:0] bits, output bit ok);
      int w;
      bits = '0;
      ok   = 1'b1;
      w    = 0;
      while (clk_oe !== 1'b1 && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (clk_oe !== 1'b1) begin
         ok = 1'b0;
         return;
      end
      w = 0;
      while (clk_oe !== 1'b0 && w < INHIBIT_CYC + 100) begin
         @(negedge clk);
         w++;
      end
      if (clk_oe !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      repeat (20) @(negedge clk);
      bits[0] = ps2_dat_line;
      for (int n = 1; n <= 11; n++) begin
         if (n == 11) begin
            if (ack) dev_dat = 1'b0;
            repeat (5) @(negedge clk);
         end
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         if (n == abort_after) return;
         dev_clk = 1'b1;
         if (n <= 10) bits[n] = ps2_dat_line;
         else dev_dat = 1'b1;
         if (n == glitch_after) begin
            repeat (10) @(negedge clk);
            dev_clk = 1'b0;
            repeat (2) @(negedge clk);
            dev_clk = 1'b1;
            repeat (HALF - 12) @(negedge clk);
         end else if (n < 11) begin
            repeat (HALF) @(negedge clk);
         end
      end
   endtask

   task automatic check_frame(input string tag, input logic [10:0] bits, input bit ok);
      logic [10:0] exp;
      check({tag, "_dev_ok"}, {31'd0, ok}, 32'd1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 11'bx;
      check({tag, "_frame"}, {21'd0, bits}, {21'd0, exp});
   endtask

   task automatic wait_done(input string tag);
      int w;
      logic [1:0] st;
      w = 0;
      while (done !== 1'b1 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      st = (exp_st_q.size() > 0) ? exp_st_q.pop_front() : 2'bxx;
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_status"}, {30'd0, status}, {30'd0, st});
      check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      check({tag, "_ready_after"}, {30'd0, tx_ready, busy}, 32'd2);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [10:0] bits;
      bit          ok;
      int          w;
      int          cnt;
      int          done_before;

      n_assert = 0;
      n_fail   = 0;
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      dev_clk  = 1'b1;
      dev_dat  = 1'b1;
      repeat (4) @(negedge clk);
      check("reset_outputs", {25'd0, tx_ready, busy, done, status, clk_oe, dat_oe}, 32'h40);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // ED, device acks
      send_cmd(8'hED, 1'b1, 1'b1, 2'b00);
      dev_rx(1'b1, 0, 0, bits, ok);
      check_frame("ed", bits, ok);
      wait_done("ed");
      check("ed_inhibit_len", last_oe_run, INHIBIT_CYC);

      // 01, device withholds ack
      send_cmd(8'h01, 1'b1, 1'b1, 2'b01);
      dev_rx(1'b0, 0, 0, bits, ok);
      check_frame("noack", bits, ok);
      wait_done("noack");

      // F4, device never clocks after release
      send_cmd(8'hF4, 1'b0, 1'b0, 2'b00);
      w = 0;
      while (clk_oe !== 1'b0 && w < INHIBIT_CYC + 100) begin
         @(negedge clk);
         w++;
      end
      check("tmo_release", {31'd0, clk_oe}, 32'd0);
      check("tmo_start_bit", {31'd0, dat_oe}, 32'd1);
      cnt = 0;
      while (done !== 1'b1 && cnt < TIMEOUT_CYC + 100) begin
         @(negedge clk);
         cnt++;
      end
      check("tmo_latency", cnt, TIMEOUT_CYC);
      check("tmo_status", {30'd0, status}, 32'd2);
      check("tmo_lines", {30'd0, clk_oe, dat_oe}, 32'd0);
      @(negedge clk);
      check("tmo_ready_after", {30'd0, tx_ready, busy}, 32'd2);

      // FF, reset after the 4th falling edge
      done_before = done_cnt;
      send_cmd(8'hFF, 1'b0, 1'b0, 2'b00);
      dev_rx(1'b1, 0, 4, bits, ok);
      check("rst_dev_ok", {31'd0, ok}, 32'd1);
      check("rst_midframe_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_midframe_lines", {27'd0, clk_oe, dat_oe, busy, tx_ready, done}, 32'd2);
      rst     = 1'b0;
      dev_clk = 1'b1;
      repeat (60) @(negedge clk);
      check("rst_no_done", done_cnt, done_before);

      // F4 after reset completes normally
      send_cmd(8'hF4, 1'b1, 1'b1, 2'b00);
      dev_rx(1'b1, 0, 0, bits, ok);
      check_frame("f4", bits, ok);
      wait_done("f4");

      // ED with AA held valid throughout, AA taken on the first ready
      send_cmd(8'hED, 1'b1, 1'b1, 2'b00);
      tx_valid = 1'b1;
      tx_data  = 8'hAA;
      exp_q.push_back(frame_of(8'hAA));
      exp_st_q.push_back(2'b00);
      dev_rx(1'b1, 0, 0, bits, ok);
      check_frame("b2b_ed", bits, ok);
      wait_done("b2b_ed");
      @(negedge clk);
      tx_valid = 1'b0;
      check("b2b_accept", {30'd0, tx_ready, busy}, 32'd1);
      dev_rx(1'b1, 0, 0, bits, ok);
      check_frame("b2b_aa", bits, ok);
      wait_done("b2b_aa");

      // 3C with a 2-cycle clock glitch after edge 3
      send_cmd(8'h3C, 1'b1, 1'b1, 2'b00);
      dev_rx(1'b1, 3, 0, bits, ok);
      check_frame("glitch", bits, ok);
      wait_done("glitch");

      repeat (10) @(negedge clk);
      check("exp_frames_left", exp_q.size(), 0);
      check("exp_status_left", exp_st_q.size(), 0);
      check("total_done", done_cnt, 7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
